p2p_relay_buffer: RTL and testbench
===================================

// Module: p2p_relay_buffer
// PURPOSE
//  Elastic relay stage between a point_slave_io receive port and a point_master_io
//  transmit port in a simbus host. Accepts WIDTH-bit words from the receive side,
//  buffers up to DEPTH+1 words and presents them to the transmit side with valid/ready.
//  The receive side can assert data while the transmit side stalls.
//  Optionally counts words the receive side offers while the buffer is full.
// PARAMETERS
//  WIDTH         8   data word width
//  DEPTH         4   FIFO memory entries; power of two, >= 2
//  DROP_ON_FULL  1   1: in_valid && !in_ready is a lost word (counted); 0: upstream holds (stall)
//  CNT_W         8   width of drop counter
// PORTS
//  clock      in   1         rising-edge clock, sole clock
//  reset_n    in   1         asynchronous, active-low reset
//  in_data    in   WIDTH     word from receive port
//  in_valid   in   1         in_data valid this cycle
//  in_ready   out  1         buffer can accept this cycle (drives receive-port resp)
//  out_data   out  WIDTH     word to transmit port (registered)
//  out_valid  out  1         out_data valid (registered)
//  out_ready  in   1         transmit side consumes out_data this cycle
//  level      out  clog2(DEPTH+2)  words held (memory + output register)
//  overflow   out  1         sticky: a word was lost (DROP_ON_FULL=1 only)
//  drop_cnt   out  CNT_W     saturating count of lost words
//  clr_stat   in   1         sync clear of overflow and drop_cnt
// BEHAVIOUR
//  - Reset (reset_n low, any time, async): pointers, mem count, out_valid, level,
//    overflow, drop_cnt -> 0; out_data -> 0; in_ready -> 1 after release.
//    Words in flight are discarded.
//  - Push: in_valid && in_ready at clock edge. Pop: out_valid && out_ready at clock edge.
//  - in_ready = (mem_count < DEPTH); combinational from registered count only, no path
//    from out_ready.
//  - Output register refill: if out reg empty or popped this edge, load the head of mem.
//    If mem is empty, load in_data directly on push (bypass).
//  - Latency: push at edge N into an empty buffer -> out_valid=1 with that word after edge N.
//  - Order is strictly FIFO. No word is duplicated or reordered, including bypass.
//  - Full (mem_count==DEPTH): in_ready=0. A simultaneous pop frees a slot only from the
//    next cycle, so there is no same-cycle push on full.
//  - Empty (level==0): out_valid=0 and out_data holds its last value.
//  - Simultaneous push and pop with mem non-empty: mem_count unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. mem_count is log2(DEPTH)+1 bits.
//  - level = mem_count + out_valid; always <= DEPTH+1.
//  - Drop (DROP_ON_FULL=1): in_valid && !in_ready -> overflow<=1; drop_cnt+=1, saturating
//    at 2^CNT_W-1. With DROP_ON_FULL=0, drops are never counted.
//  - clr_stat in the same cycle as a drop: the clear wins (overflow=0, drop_cnt=0).
//  - State per slot is implicit: EMPTY -> HOLD (push) -> EMPTY (pop). No other FSM.
// STRUCTURE
//  - p2p_relay_pkg: default WIDTH/DEPTH/CNT_W localparams; function clog2 for level
//    and pointer widths.
//  - Sub-module p2p_fifo_mem: DEPTH x WIDTH register array with one write port
//    (wr_en, wr_ptr, wr_data) and one async read port (rd_ptr).
//  - Top holds the pointers, counts, output register, bypass mux and stats.
// TESTING
//  1. Reset, then one push 0x5A with out_ready=1 -> out_valid=1 and out_data=0x5A on the
//     next cycle; level 1 then 0.
//  2. out_ready=0; push 0x01..0x06 back-to-back (DEPTH=4) -> in_ready falls after the
//     5th word, level=5; 6th word -> overflow=1, drop_cnt=1.
//  3. From the full state of test 2, set out_ready=1 continuously -> out_data
//     0x01..0x05 in order, and in_ready rises one cycle after the first pop.
//  4. Continuous push and pop for 64 cycles with an incrementing pattern -> every word
//     received in order, level stays <= 2, pointers wrap with no loss.
//  5. Hold in_valid while full for 300 cycles (CNT_W=8) -> drop_cnt saturates at 0xFF.
//     Pulse clr_stat together with a drop -> drop_cnt=0, overflow=0.
//  6. Assert reset_n low mid-burst (level=3) between clock edges -> outputs clear
//     immediately. After release, push 0xA5 -> 0xA5 is the first word out.

Source files
------------

// File: rtl/p2p_relay_buffer_pkg.sv
// Shared definitions for the p2p relay buffer.
//   DEF_WIDTH / DEF_DEPTH / DEF_CNT_W : default data width, memory depth and drop-counter width
//   clog2()                           : ceiling log2, used to size pointers and the level output
package p2p_relay_buffer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

  // Smallest r with 2**r >= value; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/p2p_relay_buffer_if.sv
// Valid/ready word stream between the relay buffer and its neighbours.
//   data  : word being offered
//   valid : data is valid this cycle
//   ready : consumer accepts data this cycle
// master drives data/valid, slave drives ready.
interface p2p_relay_buffer_if #(
  parameter int WIDTH = p2p_relay_buffer_pkg::DEF_WIDTH
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/p2p_relay_buffer_fifo_mem.sv
// DEPTH x WIDTH register array backing the relay buffer.
//   i_clk     : clock
//   i_wr_en   : write i_wr_data into slot i_wr_ptr at the rising edge
//   i_wr_ptr  : write slot
//   i_wr_data : write word
//   i_rd_ptr  : read slot
//   o_rd_data : contents of slot i_rd_ptr (combinational read)
module p2p_relay_buffer_fifo_mem
  import p2p_relay_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_wr_en,
  input  logic [clog2(DEPTH)-1:0] i_wr_ptr,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic [clog2(DEPTH)-1:0] i_rd_ptr,
  output logic [WIDTH-1:0]        o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Slot contents carry no meaning until written, so the array is not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/p2p_relay_buffer.sv
// Elastic relay stage: accepts words on i_rx, holds up to DEPTH words in memory
// plus one in a registered output stage, and presents them in order on o_tx.
//   i_clk      : rising-edge clock
//   i_rst_n    : asynchronous active-low reset
//   i_rx       : receive stream (slave); ready = memory not full
//   o_tx       : transmit stream (master); data/valid are registered
//   i_clr_stat : synchronous clear of overflow and drop count
//   o_level    : words held (memory + output register)
//   o_overflow : sticky, a word was lost while full (DROP_ON_FULL=1)
//   o_drop_cnt : saturating count of lost words
module p2p_relay_buffer
  import p2p_relay_buffer_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter bit DROP_ON_FULL = 1'b1,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  p2p_relay_buffer_if.slave         i_rx,
  p2p_relay_buffer_if.master        o_tx,
  input  logic                      i_clr_stat,
  output logic [clog2(DEPTH+2)-1:0] o_level,
  output logic                      o_overflow,
  output logic [CNT_W-1:0]          o_drop_cnt
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int MCNT_W = PTR_W + 1;
  localparam int LVL_W  = clog2(DEPTH + 2);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [MCNT_W-1:0] r_mem_count;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_out_load;
  logic              w_mem_empty;
  logic              w_mem_wr;
  logic              w_mem_rd;
  logic              w_drop;
  logic [WIDTH-1:0]  w_rd_data;

  // Ready depends only on the registered memory count, never on o_tx.ready.
  assign w_in_ready  = (r_mem_count < MCNT_W'(DEPTH));
  assign w_push      = i_rx.valid && w_in_ready;
  assign w_pop       = r_out_valid && o_tx.ready;
  assign w_out_load  = !r_out_valid || w_pop;
  assign w_mem_empty = (r_mem_count == '0);

  // A push into empty memory while the output stage is loading goes straight
  // to the output register instead of through the array.
  assign w_mem_wr = w_push && !(w_out_load && w_mem_empty);
  assign w_mem_rd = w_out_load && !w_mem_empty;
  assign w_drop   = DROP_ON_FULL && i_rx.valid && !w_in_ready;

  p2p_relay_buffer_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_mem_wr),
    .i_wr_ptr  (r_wr_ptr),
    .i_wr_data (i_rx.data),
    .i_rd_ptr  (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_mem_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_mem_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_mem_count <= r_mem_count + MCNT_W'(w_mem_wr) - MCNT_W'(w_mem_rd);
      if (w_out_load) begin
        if (!w_mem_empty) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_rd_data;
        end else if (w_push) begin
          r_out_valid <= 1'b1;
          r_out_data  <= i_rx.data;
        end else begin
          // Empty: data keeps its last value.
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  // Clear has priority over a drop in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_clr_stat) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != {CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign i_rx.ready  = w_in_ready;
  assign o_tx.valid  = r_out_valid;
  assign o_tx.data   = r_out_data;
  assign o_level     = LVL_W'(r_mem_count) + LVL_W'(r_out_valid);
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_p2p_relay_buffer.sv
module tb_p2p_relay_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_stat = 1'b0;
  logic [2:0]       level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  p2p_relay_buffer_if #(.WIDTH(WIDTH)) rx_if ();
  p2p_relay_buffer_if #(.WIDTH(WIDTH)) tx_if ();

  p2p_relay_buffer #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .DROP_ON_FULL (1'b1),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx_if),
    .o_tx       (tx_if),
    .i_clr_stat (clr_stat),
    .o_level    (level),
    .o_overflow (overflow),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Reference model: the buffer is an ordered list of held words. The head is
  // what the transmit side sees; every word except the head occupies memory.
  logic [7:0] m_q[$];
  logic [7:0] m_last = 8'h00;
  logic       m_ov   = 1'b0;
  int         m_cnt  = 0;

  function automatic int m_mem_words();
    return (m_q.size() > 0) ? m_q.size() - 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_last = 8'h00;
        m_ov   = 1'b0;
        m_cnt  = 0;
      end else begin
        automatic bit rdy  = (m_mem_words() < DEPTH);
        automatic bit push = rx_if.valid && rdy;
        automatic bit pop  = (m_q.size() > 0) && tx_if.ready;
        automatic bit drop = rx_if.valid && !rdy;
        if (pop) m_last = m_q.pop_front();
        if (push) m_q.push_back(rx_if.data);
        if (clr_stat) begin
          m_ov  = 1'b0;
          m_cnt = 0;
        end else if (drop) begin
          m_ov = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_out_valid", 32'(tx_if.valid), 32'(m_q.size() > 0));
      check("cyc_out_data", 32'(tx_if.data), 32'((m_q.size() > 0) ? m_q[0] : m_last));
      check("cyc_in_ready", 32'(rx_if.ready), 32'(m_mem_words() < DEPTH));
      check("cyc_level", 32'(level), 32'(m_q.size()));
      check("cyc_overflow", 32'(overflow), 32'(m_ov));
      check("cyc_drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] recv[$];
  int         max_level;

  initial begin
    rx_if.valid = 1'b0;
    rx_if.data  = 8'h00;
    tx_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(tx_if.valid), 32'd0);
    check("rst_in_ready", 32'(rx_if.ready), 32'd1);
    check("rst_out_data", 32'(tx_if.data), 32'h00);

    // 1: single word, one-cycle latency through the bypass
    rx_if.valid = 1'b1; rx_if.data = 8'h5A; tx_if.ready = 1'b1;
    step();
    rx_if.valid = 1'b0;
    check("t1_out_valid", 32'(tx_if.valid), 32'd1);
    check("t1_out_data", 32'(tx_if.data), 32'h5A);
    check("t1_level1", 32'(level), 32'd1);
    step();
    check("t1_level0", 32'(level), 32'd0);
    check("t1_valid0", 32'(tx_if.valid), 32'd0);

    // 2: fill while stalled, sixth word is lost
    tx_if.ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      rx_if.valid = 1'b1; rx_if.data = 8'(k);
      step();
    end
    check("t2_in_ready_full", 32'(rx_if.ready), 32'd0);
    check("t2_level_full", 32'(level), 32'd5);
    rx_if.data = 8'h06;
    step();
    rx_if.valid = 1'b0;
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_drop_cnt", 32'(drop_cnt), 32'd1);

    // 3: drain in order; ready returns one cycle after the first pop
    tx_if.ready = 1'b1;
    check("t3_in_ready_pre", 32'(rx_if.ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("t3_valid", 32'(tx_if.valid), 32'd1);
      check("t3_order", 32'(tx_if.data), 32'(k + 1));
      step();
      if (k == 0) check("t3_in_ready_post", 32'(rx_if.ready), 32'd1);
    end
    check("t3_level_empty", 32'(level), 32'd0);

    // 4: streaming push and pop
    max_level = 0;
    for (int i = 0; i < 64; i++) begin
      if (tx_if.valid) recv.push_back(tx_if.data);
      rx_if.valid = 1'b1; rx_if.data = 8'(8'h10 + i);
      if (int'(level) > max_level) max_level = int'(level);
      step();
    end
    rx_if.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tx_if.valid) recv.push_back(tx_if.data);
      if (int'(level) > max_level) max_level = int'(level);
      step();
    end
    check("t4_count", 32'(recv.size()), 32'd64);
    check("t4_max_level", 32'(max_level <= 2), 32'd1);
    for (int i = 0; i < recv.size() && i < 64; i++)
      check("t4_word", 32'(recv[i]), 32'(8'h10 + i));

    // 5: long drop burst saturates, then clear wins over a drop
    tx_if.ready = 1'b0;
    rx_if.valid = 1'b1; rx_if.data = 8'h77;
    repeat (305) step();
    check("t5_sat", 32'(drop_cnt), 32'hFF);
    check("t5_ovf", 32'(overflow), 32'd1);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    rx_if.valid = 1'b0;
    check("t5_clr_cnt", 32'(drop_cnt), 32'd0);
    check("t5_clr_ovf", 32'(overflow), 32'd0);
    tx_if.ready = 1'b1;
    repeat (6) step();
    check("t5_drained", 32'(level), 32'd0);

    // 6: asynchronous reset mid-burst
    tx_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_if.valid = 1'b1; rx_if.data = 8'(8'h31 + k);
      step();
    end
    rx_if.data = 8'h34;
    check("t6_level3", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_valid", 32'(tx_if.valid), 32'd0);
    check("t6_rst_data", 32'(tx_if.data), 32'h00);
    check("t6_rst_ready", 32'(rx_if.ready), 32'd1);
    rx_if.valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    rx_if.valid = 1'b1; rx_if.data = 8'hA5; tx_if.ready = 1'b1;
    step();
    rx_if.valid = 1'b0;
    check("t6_first_valid", 32'(tx_if.valid), 32'd1);
    check("t6_first_word", 32'(tx_if.data), 32'hA5);
    step();
    check("t6_level_end", 32'(level), 32'd0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
